// File: rtl/rs_dispatch_station.sv
// Reservation station: holds dispatched uops until both operands are ready, snoops the CDB,
// and issues the oldest ready uop. Optional macro RS_CDB_BYPASS_EN enables dispatch-time CDB capture.
module rs_dispatch_station #(
    parameter int          ENTRIES    = 4,
    parameter int          TAG_W      = 9,
    parameter int          DATA_W     = 32,
    parameter logic [3:0]  STATION_ID = 4'd1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [3:0]                    disp_station,
    input  logic [5:0]                    disp_alu_fn,
    input  logic [TAG_W-1:0]              disp_dest_tag,
    input  logic                          disp_src1_rdy,
    input  logic                          disp_src2_rdy,
    input  logic [TAG_W-1:0]              disp_src1_tag,
    input  logic [TAG_W-1:0]              disp_src2_tag,
    input  logic [DATA_W-1:0]             disp_src1_val,
    input  logic [DATA_W-1:0]             disp_src2_val,
    input  logic                          disp_use_imm,
    input  logic [15:0]                   disp_imm,
    input  logic                          cdb_valid,
    input  logic [TAG_W-1:0]              cdb_tag,
    input  logic [DATA_W-1:0]             cdb_val,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [5:0]                    issue_alu_fn,
    output logic [TAG_W-1:0]              issue_dest_tag,
    output logic [DATA_W-1:0]             issue_op1,
    output logic [DATA_W-1:0]             issue_op2,
    output logic [$clog2(ENTRIES+1)-1:0]  occupancy
);

    localparam int AGE_W = $clog2(ENTRIES);
    localparam int OCC_W = $clog2(ENTRIES+1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(ENTRIES-1);

    logic              valid_q [ENTRIES];
    logic              valid_d [ENTRIES];
    logic [5:0]        fn_q    [ENTRIES];
    logic [5:0]        fn_d    [ENTRIES];
    logic [TAG_W-1:0]  dest_q  [ENTRIES];
    logic [TAG_W-1:0]  dest_d  [ENTRIES];
    logic              rdy1_q  [ENTRIES];
    logic              rdy1_d  [ENTRIES];
    logic              rdy2_q  [ENTRIES];
    logic              rdy2_d  [ENTRIES];
    logic [TAG_W-1:0]  tag1_q  [ENTRIES];
    logic [TAG_W-1:0]  tag1_d  [ENTRIES];
    logic [TAG_W-1:0]  tag2_q  [ENTRIES];
    logic [TAG_W-1:0]  tag2_d  [ENTRIES];
    logic [DATA_W-1:0] val1_q  [ENTRIES];
    logic [DATA_W-1:0] val1_d  [ENTRIES];
    logic [DATA_W-1:0] val2_q  [ENTRIES];
    logic [DATA_W-1:0] val2_d  [ENTRIES];
    logic [AGE_W-1:0]  age_q   [ENTRIES];
    logic [AGE_W-1:0]  age_d   [ENTRIES];

    logic              hasFree;
    logic [AGE_W-1:0]  freeIdx;
    logic              selValid;
    logic [AGE_W-1:0]  selIdx;
    logic [AGE_W-1:0]  selAge;
    logic              accept;
    logic              fire;
    logic              newRdy1;
    logic              newRdy2;
    logic [DATA_W-1:0] newVal1;
    logic [DATA_W-1:0] newVal2;
    logic [OCC_W-1:0]  occCount;

    // Lowest-index free slot (scan downward so the lowest index wins).
    always_comb begin
        hasFree = 1'b0;
        freeIdx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                hasFree = 1'b1;
                freeIdx = AGE_W'(i);
            end
        end
    end

    // Oldest ready entry; strict comparison leaves ties with the lowest index.
    always_comb begin
        selValid = 1'b0;
        selIdx   = '0;
        selAge   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i] && (!selValid || age_q[i] > selAge)) begin
                selValid = 1'b1;
                selIdx   = AGE_W'(i);
                selAge   = age_q[i];
            end
        end
    end

    always_comb begin
        occCount = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occCount = occCount + OCC_W'(valid_q[i]);
        end
    end

`ifdef RS_CDB_BYPASS_EN
    assign disp_ready = hasFree;
    assign newRdy1 = disp_src1_rdy | (cdb_valid & (disp_src1_tag == cdb_tag));
    assign newVal1 = disp_src1_rdy ? disp_src1_val : cdb_val;
    assign newRdy2 = disp_use_imm | disp_src2_rdy | (cdb_valid & (disp_src2_tag == cdb_tag));
    assign newVal2 = disp_use_imm  ? {{(DATA_W-16){disp_imm[15]}}, disp_imm} :
                     disp_src2_rdy ? disp_src2_val : cdb_val;
`else
    // Dispatch is held off during a broadcast so a new entry can never miss its producer.
    assign disp_ready = hasFree & ~cdb_valid;
    assign newRdy1 = disp_src1_rdy;
    assign newVal1 = disp_src1_val;
    assign newRdy2 = disp_use_imm | disp_src2_rdy;
    assign newVal2 = disp_use_imm ? {{(DATA_W-16){disp_imm[15]}}, disp_imm} : disp_src2_val;
`endif

    assign accept      = disp_valid & disp_ready & (disp_station == STATION_ID) & ~flush & ~reset;
    assign issue_valid = selValid & ~flush & ~reset;
    assign fire        = issue_valid & issue_ready;
    assign occupancy   = occCount;

    assign issue_alu_fn   = issue_valid ? fn_q[selIdx]   : '0;
    assign issue_dest_tag = issue_valid ? dest_q[selIdx] : '0;
    assign issue_op1      = issue_valid ? val1_q[selIdx] : '0;
    assign issue_op2      = issue_valid ? val2_q[selIdx] : '0;

    // Next state: wakeup, issue clear, dispatch write with aging, then flush override.
    always_comb begin
        valid_d = valid_q;
        fn_d    = fn_q;
        dest_d  = dest_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        age_d   = age_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && cdb_valid) begin
                if (!rdy1_q[i] && tag1_q[i] == cdb_tag) begin
                    rdy1_d[i] = 1'b1;
                    val1_d[i] = cdb_val;
                end
                if (!rdy2_q[i] && tag2_q[i] == cdb_tag) begin
                    rdy2_d[i] = 1'b1;
                    val2_d[i] = cdb_val;
                end
            end
        end
        if (fire) begin
            valid_d[selIdx] = 1'b0;
        end
        if (accept) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid_q[i] && age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
            valid_d[freeIdx] = 1'b1;
            fn_d[freeIdx]    = disp_alu_fn;
            dest_d[freeIdx]  = disp_dest_tag;
            rdy1_d[freeIdx]  = newRdy1;
            tag1_d[freeIdx]  = disp_src1_tag;
            val1_d[freeIdx]  = newVal1;
            rdy2_d[freeIdx]  = newRdy2;
            tag2_d[freeIdx]  = disp_src2_tag;
            val2_d[freeIdx]  = newVal2;
            age_d[freeIdx]   = '0;
        end
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                fn_q[i]    <= '0;
                dest_q[i]  <= '0;
                rdy1_q[i]  <= 1'b0;
                rdy2_q[i]  <= 1'b0;
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            fn_q    <= fn_d;
            dest_q  <= dest_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_rs_dispatch_station.sv
// Directed self-checking bench for rs_dispatch_station with default parameters.
module tb_rs_dispatch_station;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        dispValid;
    logic        dispReady;
    logic [3:0]  dispStation;
    logic [5:0]  dispAluFn;
    logic [8:0]  dispDestTag;
    logic        dispSrc1Rdy;
    logic        dispSrc2Rdy;
    logic [8:0]  dispSrc1Tag;
    logic [8:0]  dispSrc2Tag;
    logic [31:0] dispSrc1Val;
    logic [31:0] dispSrc2Val;
    logic        dispUseImm;
    logic [15:0] dispImm;
    logic        cdbValid;
    logic [8:0]  cdbTag;
    logic [31:0] cdbVal;
    logic        issueValid;
    logic        issueReady;
    logic [5:0]  issueAluFn;
    logic [8:0]  issueDestTag;
    logic [31:0] issueOp1;
    logic [31:0] issueOp2;
    logic [2:0]  occupancy;

    int checkCount = 0;
    int errorCount = 0;

    rs_dispatch_station dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(dispValid), .disp_ready(dispReady), .disp_station(dispStation),
        .disp_alu_fn(dispAluFn), .disp_dest_tag(dispDestTag),
        .disp_src1_rdy(dispSrc1Rdy), .disp_src2_rdy(dispSrc2Rdy),
        .disp_src1_tag(dispSrc1Tag), .disp_src2_tag(dispSrc2Tag),
        .disp_src1_val(dispSrc1Val), .disp_src2_val(dispSrc2Val),
        .disp_use_imm(dispUseImm), .disp_imm(dispImm),
        .cdb_valid(cdbValid), .cdb_tag(cdbTag), .cdb_val(cdbVal),
        .issue_valid(issueValid), .issue_ready(issueReady),
        .issue_alu_fn(issueAluFn), .issue_dest_tag(issueDestTag),
        .issue_op1(issueOp1), .issue_op2(issueOp2), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Advance one clock and let outputs settle before the next drive/check.
    task automatic step();
        @(posedge clk);
        #1;
        dispValid = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic [8:0] dest, input logic r1, input logic [8:0] t1,
                                 input logic [31:0] v1, input logic r2, input logic [31:0] v2);
        dispValid   = 1'b1;
        dispStation = 4'd1;
        dispAluFn   = 6'h03;
        dispDestTag = dest;
        dispSrc1Rdy = r1;
        dispSrc1Tag = t1;
        dispSrc1Val = v1;
        dispSrc2Rdy = r2;
        dispSrc2Tag = 9'h1FF;
        dispSrc2Val = v2;
        dispUseImm  = 1'b0;
        dispImm     = 16'h0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; issueReady = 1'b0;
        cdbValid = 1'b0; cdbTag = '0; cdbVal = '0;
        applyStimulus(9'h0, 1'b1, 9'h0, 32'h0, 1'b1, 32'h0);
        dispValid = 1'b0;
        step(); step();
        reset = 1'b0;
        settle();
        checkOutput("rst_issue_valid", 32'(issueValid), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_disp_ready", 32'(dispReady), 32'd1);
        checkOutput("rst_op1", issueOp1, 32'd0);
        checkOutput("rst_dest", 32'(issueDestTag), 32'd0);

        // Basic dispatch and issue
        applyStimulus(9'h021, 1'b1, 9'h0, 32'h5, 1'b1, 32'h7);
        step();
        issueReady = 1'b1;
        settle();
        checkOutput("t1_issue_valid", 32'(issueValid), 32'd1);
        checkOutput("t1_op1", issueOp1, 32'h5);
        checkOutput("t1_op2", issueOp2, 32'h7);
        checkOutput("t1_dest", 32'(issueDestTag), 32'h021);
        checkOutput("t1_fn", 32'(issueAluFn), 32'h03);
        checkOutput("t1_occ1", 32'(occupancy), 32'd1);
        step();
        issueReady = 1'b0;
        settle();
        checkOutput("t1_occ0", 32'(occupancy), 32'd0);
        checkOutput("t1_idle", 32'(issueValid), 32'd0);

        // CDB wakeup
        applyStimulus(9'h022, 1'b0, 9'h040, 32'h0, 1'b1, 32'h1);
        step();
        checkOutput("t2_wait_valid", 32'(issueValid), 32'd0);
        checkOutput("t2_occ", 32'(occupancy), 32'd1);
        step(); step(); step();
        checkOutput("t2_still_wait", 32'(issueValid), 32'd0);
        cdbValid = 1'b1; cdbTag = 9'h040; cdbVal = 32'hDEAD;
        settle();
        checkOutput("t2_pre_bcast_valid", 32'(issueValid), 32'd0);
`ifdef RS_CDB_BYPASS_EN
        checkOutput("t2_bcast_disp_ready", 32'(dispReady), 32'd1);
`else
        checkOutput("t2_bcast_disp_ready", 32'(dispReady), 32'd0);
`endif
        step();
        cdbValid = 1'b0;
        settle();
        checkOutput("t2_woke_valid", 32'(issueValid), 32'd1);
        checkOutput("t2_woke_op1", issueOp1, 32'hDEAD);
        issueReady = 1'b1;
        step();
        issueReady = 1'b0;
        settle();
        checkOutput("t2_occ0", 32'(occupancy), 32'd0);

        // Fill all four slots
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(9'(i), 1'b1, 9'h0, 32'(i), 1'b1, 32'h0);
            step();
        end
        checkOutput("t3_full_occ", 32'(occupancy), 32'd4);
        checkOutput("t3_full_ready", 32'(dispReady), 32'd0);
        applyStimulus(9'h005, 1'b1, 9'h0, 32'h5, 1'b1, 32'h0);
        step();
        checkOutput("t3_fifth_dropped", 32'(occupancy), 32'd4);
        checkOutput("t3_oldest", 32'(issueDestTag), 32'h001);
        issueReady = 1'b1;
        settle();
        checkOutput("t3_full_during_issue", 32'(dispReady), 32'd0);
        step();
        issueReady = 1'b0;
        settle();
        checkOutput("t3_ready_after", 32'(dispReady), 32'd1);
        checkOutput("t3_occ3", 32'(occupancy), 32'd3);
        checkOutput("t3_next_oldest", 32'(issueDestTag), 32'h002);

        // Flush with three entries
        flush = 1'b1;
        settle();
        checkOutput("t6_flush_issue_valid", 32'(issueValid), 32'd0);
        step();
        flush = 1'b0;
        settle();
        checkOutput("t6_flush_occ", 32'(occupancy), 32'd0);
        checkOutput("t6_flush_after_valid", 32'(issueValid), 32'd0);

        // Age ordering with a waiting older entry
        applyStimulus(9'h00A, 1'b0, 9'h010, 32'h0, 1'b1, 32'h0);
        step();
        applyStimulus(9'h00B, 1'b1, 9'h0, 32'hB, 1'b1, 32'h0);
        step();
        applyStimulus(9'h00C, 1'b1, 9'h0, 32'hC, 1'b1, 32'h0);
        step();
        checkOutput("t4_b_first", 32'(issueDestTag), 32'h00B);
        issueReady = 1'b1;
        step();
        checkOutput("t4_c_second", 32'(issueDestTag), 32'h00C);
        step();
        issueReady = 1'b0;
        settle();
        checkOutput("t4_a_waiting", 32'(issueValid), 32'd0);
        checkOutput("t4_occ1", 32'(occupancy), 32'd1);
        applyStimulus(9'h00D, 1'b1, 9'h0, 32'hD, 1'b1, 32'h0);
        step();
        checkOutput("t4_d_alone", 32'(issueDestTag), 32'h00D);
        cdbValid = 1'b1; cdbTag = 9'h010; cdbVal = 32'h11;
        step();
        cdbValid = 1'b0;
        settle();
        checkOutput("t4_a_before_d", 32'(issueDestTag), 32'h00A);
        checkOutput("t4_a_op1", issueOp1, 32'h11);
        issueReady = 1'b1;
        step();
        checkOutput("t4_d_last", 32'(issueDestTag), 32'h00D);
        step();
        issueReady = 1'b0;
        settle();
        checkOutput("t4_occ0", 32'(occupancy), 32'd0);

        // Immediate and station mismatch
        applyStimulus(9'h030, 1'b1, 9'h0, 32'h1, 1'b0, 32'h12345678);
        dispSrc2Tag = 9'h0AA;
        dispUseImm  = 1'b1;
        dispImm     = 16'hFFFE;
        step();
        checkOutput("t5_imm_valid", 32'(issueValid), 32'd1);
        checkOutput("t5_imm_op2", issueOp2, 32'hFFFFFFFE);
        issueReady = 1'b1;
        step();
        issueReady = 1'b0;
        applyStimulus(9'h031, 1'b1, 9'h0, 32'h1, 1'b1, 32'h2);
        dispStation = 4'd2;
        step();
        checkOutput("t5_station_occ", 32'(occupancy), 32'd0);
        checkOutput("t5_station_valid", 32'(issueValid), 32'd0);

        // Dispatch coincident with a matching broadcast
        cdbValid = 1'b1; cdbTag = 9'h055; cdbVal = 32'hBEEF;
        applyStimulus(9'h032, 1'b0, 9'h055, 32'h0, 1'b1, 32'h2);
        settle();
`ifdef RS_CDB_BYPASS_EN
        checkOutput("t6_byp_disp_ready", 32'(dispReady), 32'd1);
        step();
        cdbValid = 1'b0;
        settle();
        checkOutput("t6_byp_occ", 32'(occupancy), 32'd1);
        checkOutput("t6_byp_valid", 32'(issueValid), 32'd1);
        checkOutput("t6_byp_op1", issueOp1, 32'hBEEF);
`else
        checkOutput("t6_nobyp_disp_ready", 32'(dispReady), 32'd0);
        step();
        cdbValid = 1'b0;
        settle();
        checkOutput("t6_nobyp_occ", 32'(occupancy), 32'd0);
        checkOutput("t6_nobyp_valid", 32'(issueValid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
